// File: rtl/acumulador_pkg.sv
// Shared definitions for the accumulator that wraps the external 16-bit adder.
// Holds the default widths and the controller state type.
package acumulador_pkg;

  localparam int N_DEF     = 16;  // operand / accumulator width, matches the adder
  localparam int LEN_W_DEF = 8;   // width of burst length and beat count

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACUM   = 2'd1,
    SALIDA = 2'd2
  } state_t;

endpackage

// File: rtl/acumulador_sumador.sv
// Burst accumulator placed around an external combinational adder.
// A burst of len operands is streamed in over a valid/ready input port.
// Each accepted operand is added to the accumulator through the adder, and the
// adder Sum is fed back as the next A operand. The final sum, a sticky carry-out
// flag and the beat count are then offered over a valid/ready output port.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, len        begin a burst of len operands (sampled only in IDLE)
//   in_valid/in_ready operand handshake; in_data/in_cin are the operand and its carry-in
//   add_a/add_b/add_cin  adder inputs (A is always the accumulator)
//   add_sum/add_cout     adder outputs
//   out_valid/out_ready  result handshake; out_acc/out_ovf/out_count are the result
//   busy              high whenever the controller is not IDLE
module acumulador_sumador
  import acumulador_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_cin,
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  output logic             add_cin,
  input  logic [N-1:0]     add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_acc,
  output logic             out_ovf,
  output logic [LEN_W-1:0] out_count,
  output logic             busy
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state;
  logic [N-1:0]     acc;
  logic             ovf;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] remaining;  // beats still to accept in this burst

  wire beat = in_valid && in_ready;

  // Controller, datapath registers and the registered handshake flags.
  // in_ready, out_valid and busy are updated together with state, so each is
  // exactly "state is ACUM / SALIDA / not IDLE" without decode glitches.
  // NOTE: all state is written with non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      remaining <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            remaining <= len;
            busy      <= 1'b1;
            if (len == '0) begin
              state     <= SALIDA;
              out_valid <= 1'b1;
            end else begin
              state    <= ACUM;
              in_ready <= 1'b1;
            end
          end
        end

        ACUM: begin
          if (beat) begin
            acc       <= add_sum;
            ovf       <= ovf | add_cout;
            cnt       <= cnt + ONE;
            remaining <= remaining - ONE;
            // Last beat: equivalent to cnt+1 == len, so cnt never exceeds len.
            if (remaining == ONE) begin
              state     <= SALIDA;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end

        SALIDA: begin
          // start is not looked at here; a start coinciding with the
          // handshake is only seen on the following cycle in IDLE.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Adder drive: the operand only reaches the adder while accepting beats,
  // otherwise the adder just sees acc + 0.
  assign add_a   = acc;
  assign add_b   = in_ready ? in_data : '0;
  assign add_cin = in_ready ? in_cin : 1'b0;

  // Result fields are zero unless a result is being offered.
  assign out_acc   = out_valid ? acc : '0;
  assign out_ovf   = out_valid ? ovf : 1'b0;
  assign out_count = out_valid ? cnt : '0;

endmodule

// File: tb/tb_acumulador_sumador.sv
// Self-checking bench for acumulador_sumador with a behavioural adder beside it.
module tb_acumulador_sumador;
  import acumulador_pkg::*;

  localparam int N     = 16;
  localparam int LEN_W = 8;
  localparam int MAXB  = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_cin;
  logic [N-1:0]     add_a;
  logic [N-1:0]     add_b;
  logic             add_cin;
  logic [N-1:0]     add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_acc;
  logic             out_ovf;
  logic [LEN_W-1:0] out_count;
  logic             busy;

  always #5 clk = ~clk;

  // External adder as the parent would place it.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  acumulador_sumador #(.N(N), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_ovf(out_ovf), .out_count(out_count), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Burst description shared by the table and the random loop.
  logic [N-1:0] b_data [MAXB];
  logic         b_cin  [MAXB];
  int           b_gap  [MAXB];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a burst with the result left pending (out_ready=0), then checks the
  // result against the expected values and completes the handshake.
  task automatic run_burst(input string tag, input int n, input logic [N-1:0] e_acc,
                           input logic e_ovf, input logic [LEN_W-1:0] e_cnt);
    int  waited;
    bit  saw_ready;
    saw_ready = 0;
    out_ready = 1'b0;
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < b_gap[i]; g++) begin
        in_valid = 1'b0;
        tick();
        check({tag, " no beat while idle input"}, {31'd0, out_valid}, 32'd0);
      end
      in_valid = 1'b1;
      in_data  = b_data[i];
      in_cin   = b_cin[i];
      waited = 0;
      while (!in_ready && waited < 20) begin
        tick();
        waited++;
      end
      if (!in_ready) check({tag, " in_ready timeout"}, 32'd0, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    if (n == 0) saw_ready = in_ready;
    check({tag, " in_ready"}, {31'd0, saw_ready}, 32'd0);
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " out_acc"}, {16'd0, out_acc}, {16'd0, e_acc});
    check({tag, " out_ovf"}, {31'd0, out_ovf}, {31'd0, e_ovf});
    check({tag, " out_count"}, {24'd0, out_count}, {24'd0, e_cnt});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " idle after handshake"}, {30'd0, out_valid, busy}, 32'd0);
  endtask

  typedef struct {
    string              name;
    int                 n;
    logic [3:0][N-1:0]  data;
    logic [3:0]         cin;
    int                 gap;   // idle cycles before every beat after the first
    logic [N-1:0]       e_acc;
    logic               e_ovf;
    logic [LEN_W-1:0]   e_cnt;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [N-1:0] held_acc;
    logic [LEN_W-1:0] held_cnt;
    logic held_ovf;
    int full;

    vecs[0] = '{"basic",    3, {16'h0000, 16'h0003, 16'h0002, 16'h0001}, 4'b0000, 0, 16'h0006, 1'b0, 8'd3};
    vecs[1] = '{"overflow", 2, {16'h0000, 16'h0000, 16'h0001, 16'hFFFF}, 4'b0000, 0, 16'h0000, 1'b1, 8'd2};
    vecs[2] = '{"cin_gaps", 2, {16'h0000, 16'h0000, 16'h5555, 16'hAAAA}, 4'b0001, 3, 16'h0000, 1'b1, 8'd2};
    vecs[3] = '{"len0",     0, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 4'b0000, 0, 16'h0000, 1'b0, 8'd0};

    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_data = '0; in_cin = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("reset flags", {28'd0, in_ready, out_valid, busy, out_ovf}, 32'd0);
    check("reset acc/count", {8'd0, out_acc, out_count}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table vectors.
    foreach (vecs[k]) begin
      for (int i = 0; i < MAXB; i++) begin
        b_data[i] = (i < 4) ? vecs[k].data[i] : '0;
        b_cin[i]  = (i < 4) ? vecs[k].cin[i] : 1'b0;
        b_gap[i]  = (i > 0) ? vecs[k].gap : 0;
      end
      run_burst(vecs[k].name, vecs[k].n, vecs[k].e_acc, vecs[k].e_ovf, vecs[k].e_cnt);
      tick();
    end

    // Reset in the middle of a 4-beat burst after 2 beats.
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h1111; in_cin = 1'b0;
    tick(); tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset flags", {29'd0, in_ready, out_valid, busy}, 32'd0);
    check("midreset outputs", {7'd0, out_ovf, out_acc, out_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post reset quiet", {30'd0, out_valid, busy}, 32'd0);
    end
    b_data[0] = 16'h0005; b_cin[0] = 1'b0; b_gap[0] = 0;
    run_burst("after_reset", 1, 16'h0005, 1'b0, 8'd1);
    tick();

    // Backpressure: result held for 5 cycles while start pulses.
    b_data[0] = 16'h1234; b_data[1] = 16'h0FFF; b_cin[0] = 1'b1; b_cin[1] = 1'b0;
    b_gap[0] = 0; b_gap[1] = 0;
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = b_data[0]; in_cin = b_cin[0];
    tick();
    in_data = b_data[1]; in_cin = b_cin[1];
    tick();
    in_valid = 1'b0;
    held_acc = out_acc; held_ovf = out_ovf; held_cnt = out_count;
    check("bp acc", {16'd0, held_acc}, 32'h2234);
    for (int c = 0; c < 5; c++) begin
      start = c[0];
      len = 8'd7;
      tick();
      check("bp held valid", {31'd0, out_valid}, 32'd1);
      check("bp held result", {7'd0, out_ovf, out_acc, out_count},
            {7'd0, held_ovf, held_acc, held_cnt});
    end
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp idle after release", {30'd0, out_valid, busy}, 32'd0);
    start = 1'b0;
    tick();
    check("bp start at handshake ignored", {31'd0, busy}, 32'd0);

    // Random bursts against an arithmetic model: the result is the full
    // integer sum reduced mod 2^N; overflow is whether that sum reached 2^N.
    for (int t = 0; t < 30; t++) begin
      int n;
      n = int'($urandom_range(1, 8));
      full = 0;
      for (int i = 0; i < n; i++) begin
        b_data[i] = N'($urandom);
        b_cin[i]  = 1'($urandom);
        b_gap[i]  = int'($urandom_range(0, 2));
        full += int'(b_data[i]) + int'(b_cin[i]);
      end
      run_burst($sformatf("rand%0d", t), n, N'(full), full >= (1 << N), LEN_W'(n));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
